// File: rtl/apb_cmd_queue.sv
// rtl/apb_cmd_queue.sv - command FIFO and single-outstanding issue FSM in front of apb_master
module apb_cmd_queue #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [1:0]        cmd_size,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic [1:0]        processs,
  output logic [1:0]        data_size,
  input  logic [DATA_W-1:0] read_data,
  input  logic              xfer_done
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  state_t state, state_nxt;

  logic              q_write [DEPTH];
  logic [ADDR_W-1:0] q_addr  [DEPTH];
  logic [DATA_W-1:0] q_wdata [DEPTH];
  logic [1:0]        q_size  [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tcnt;
  logic          push, pop, head_bad, cur_write, timed_out;

  // cmd_ready looks at count only, so a full queue never pushes on the cycle it pops
  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign timed_out = (tcnt == TO_LAST);

  always_comb begin
    head_bad = 1'b0;
    case (q_size[rd_ptr])
      2'b01:   head_bad = q_addr[rd_ptr][0];
      2'b10:   head_bad = (q_addr[rd_ptr][1:0] != 2'b00);
      2'b11:   head_bad = 1'b1;
      default: head_bad = 1'b0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (push) begin
      q_write[wr_ptr] <= cmd_write;
      q_addr[wr_ptr]  <= cmd_addr;
      q_wdata[wr_ptr] <= cmd_wdata;
      q_size[wr_ptr]  <= cmd_size;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (count != '0) state_nxt = head_bad ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (xfer_done || timed_out) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    processs  = 2'b00;
    rsp_valid = 1'b0;
    case (state)
      S_ISSUE: processs  = cur_write ? 2'b01 : 2'b10;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Bus-facing fields are only loaded for commands that will really reach the bus
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      address    <= '0;
      write_data <= '0;
      data_size  <= '0;
      cur_write  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      tcnt       <= '0;
    end else begin
      if (pop && !head_bad) begin
        address    <= q_addr[rd_ptr];
        write_data <= q_wdata[rd_ptr];
        data_size  <= q_size[rd_ptr];
        cur_write  <= q_write[rd_ptr];
      end
      case (state)
        S_IDLE: begin
          if (pop && head_bad) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        S_ISSUE: tcnt <= '0;
        S_WAIT: begin
          tcnt <= tcnt + TW'(1);
          if (xfer_done) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= cur_write ? '0 : read_data;
          end else if (timed_out) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_queue.sv
// tb/tb_apb_cmd_queue.sv - directed and randomized checks of apb_cmd_queue against a queue model
module tb_apb_cmd_queue;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int N_RAND  = 60;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
  } cmd_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } res_t;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata, address, write_data, read_data;
  logic [1:0]  processs, data_size;
  logic        xfer_done;

  logic        bg_on = 1'b0;
  logic        bg_xfer = 1'b0, dir_xfer = 1'b0, bg_ready = 1'b0, dir_ready = 1'b0;
  logic [31:0] bg_rdata = 32'h0, dir_rdata = 32'h0;

  assign xfer_done = bg_on ? bg_xfer  : dir_xfer;
  assign read_data = bg_on ? bg_rdata : dir_rdata;
  assign rsp_ready = bg_on ? bg_ready : dir_ready;

  int   checks = 0, errors = 0;
  int   n_pushed = 0, n_rsp = 0, sel, nresp;
  cmd_t exp_q[$], bus_q[$];
  res_t res_q[$];
  cmd_t nc, rs_c, rc_c;
  res_t rc_r;
  int   rs_k;
  logic [31:0] rs_rd;
  logic rc_rdy, rc_took = 1'b0, saw_issue, saw_rsp;

  apb_cmd_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .write_data(write_data), .processs(processs), .data_size(data_size),
    .read_data(read_data), .xfer_done(xfer_done)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // A transfer is legal when the address is a multiple of the access width in bytes
  function automatic logic is_bad(cmd_t c);
    int unsigned bytes;
    if (c.s == 2'b11) return 1'b1;
    bytes = 1 << c.s;
    return (c.a % bytes) != 0;
  endfunction

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_size = s;
    while (!cmd_ready && n < 200) begin @(negedge PCLK); n++; end
    check_eq("push_ready", cmd_ready, 1);
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (processs == 2'b00 && n < 100) begin @(negedge PCLK); n++; end
    check_eq({tag, "_issued"}, 32'(processs != 2'b00), 1);
  endtask

  task automatic finish_xfer(input int k, input logic [31:0] rd);
    repeat (k) @(negedge PCLK);
    dir_xfer = 1'b1; dir_rdata = rd;
    @(negedge PCLK);
    dir_xfer = 1'b0; dir_rdata = $urandom;
    check_eq("rsp_latency", rsp_valid, 1);
  endtask

  task automatic take_rsp(input string tag, input logic err, input logic [31:0] rd);
    int n = 0;
    while (!rsp_valid && n < 100) begin @(negedge PCLK); n++; end
    check_eq({tag, "_valid"}, rsp_valid, 1);
    check_eq({tag, "_err"}, rsp_err, err);
    check_eq({tag, "_rdata"}, rsp_rdata, rd);
    dir_ready = 1'b1;
    @(negedge PCLK);
    dir_ready = 1'b0;
    check_eq({tag, "_drop"}, rsp_valid, 0);
  endtask

  // Random-phase bus responder: checks what is issued and decides how the bus answers
  initial begin
    forever begin
      @(negedge PCLK);
      if (bg_on && processs != 2'b00) begin
        if (bus_q.size() == 0) begin
          check_eq("r_unexpected_issue", processs, 0);
        end else begin
          rs_c = bus_q.pop_front();
          check_eq("r_op", processs, rs_c.w ? 32'd1 : 32'd2);
          check_eq("r_addr", address, rs_c.a);
          check_eq("r_size", data_size, rs_c.s);
          if (rs_c.w) check_eq("r_wdata", write_data, rs_c.d);
          if ($urandom_range(0, 7) == 0) begin
            res_q.push_back('{1'b1, 32'h0});
            repeat (TIMEOUT) @(negedge PCLK);
            check_eq("r_to_early", rsp_valid, 0);
            @(negedge PCLK);
            check_eq("r_to_rsp", rsp_valid, 1);
          end else begin
            rs_k  = $urandom_range(1, TIMEOUT);
            rs_rd = $urandom;
            res_q.push_back('{1'b0, rs_c.w ? 32'h0 : rs_rd});
            repeat (rs_k) @(negedge PCLK);
            check_eq("r_hold_addr", address, rs_c.a);
            check_eq("r_idle_wait", processs, 0);
            bg_xfer = 1'b1; bg_rdata = rs_rd;
            @(negedge PCLK);
            bg_xfer = 1'b0; bg_rdata = $urandom;
            check_eq("r_rsp_lat", rsp_valid, 1);
          end
        end
      end
    end
  end

  // Random-phase response consumer: in-order scoreboard with random backpressure
  initial begin
    forever begin
      @(negedge PCLK);
      if (bg_on) begin
        if (rc_took) check_eq("c_drop", rsp_valid, 0);
        rc_took  = 1'b0;
        rc_rdy   = ($urandom_range(0, 3) != 0);
        bg_ready = rc_rdy;
        if (rsp_valid && rc_rdy) begin
          if (exp_q.size() == 0) begin
            check_eq("c_unexpected_rsp", rsp_valid, 0);
          end else begin
            rc_c = exp_q.pop_front();
            if (is_bad(rc_c)) begin
              rc_r = '{1'b1, 32'h0};
            end else begin
              check_eq("c_bus_seen", res_q.size(), 1);
              if (res_q.size() > 0) rc_r = res_q.pop_front();
              else rc_r = '{1'b0, 32'h0};
            end
            check_eq("c_err", rsp_err, rc_r.err);
            check_eq("c_rdata", rsp_rdata, rc_r.rdata);
            n_rsp++;
            rc_took = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_size = '0;
    #12;
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_address", address, 0);
    check_eq("rst_write_data", write_data, 0);
    check_eq("rst_processs", processs, 0);
    check_eq("rst_data_size", data_size, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    @(negedge PCLK); PRESETn = 1'b1;
    @(negedge PCLK);

    push_cmd(1'b1, 32'h10, 32'hA5A5_0001, 2'b10);
    check_eq("wr_pre_issue", processs, 0);
    @(negedge PCLK);
    check_eq("wr_issue", processs, 2'b01);
    check_eq("wr_addr", address, 32'h10);
    check_eq("wr_wdata", write_data, 32'hA5A5_0001);
    check_eq("wr_size", data_size, 2'b10);
    @(negedge PCLK);
    check_eq("wr_one_cycle", processs, 0);
    finish_xfer(2, 32'h0);
    check_eq("wr_addr_held", address, 32'h10);
    take_rsp("wr", 1'b0, 32'h0);

    push_cmd(1'b0, 32'h24, 32'h0, 2'b10);
    wait_issue("rd");
    check_eq("rd_op", processs, 2'b10);
    check_eq("rd_addr", address, 32'h24);
    finish_xfer(1, 32'hDEAD_BEEF);
    take_rsp("rd", 1'b0, 32'hDEAD_BEEF);

    push_cmd(1'b0, 32'h100, 32'h0, 2'b10);
    wait_issue("full0");
    for (int i = 1; i <= DEPTH; i++) begin
      check_eq("full_ready", cmd_ready, 1);
      push_cmd(1'b0, 32'h100 + 32'(4 * i), 32'h0, 2'b10);
    end
    check_eq("full_block", cmd_ready, 0);
    fork
      push_cmd(1'b0, 32'h100 + 32'(4 * (DEPTH + 1)), 32'h0, 2'b10);
    join_none
    repeat (2) begin
      @(negedge PCLK);
      check_eq("full_hold", cmd_ready, 0);
    end
    finish_xfer(1, 32'h1000);
    take_rsp("full0", 1'b0, 32'h1000);
    for (int i = 1; i <= DEPTH + 1; i++) begin
      wait_issue("full");
      check_eq("full_order", address, 32'h100 + 32'(4 * i));
      finish_xfer(1, 32'h1000 + 32'(i));
      take_rsp("full", 1'b0, 32'h1000 + 32'(i));
    end

    push_cmd(1'b0, 32'h3, 32'h0, 2'b01);
    push_cmd(1'b1, 32'h6, 32'h1234, 2'b10);
    saw_issue = 1'b0; nresp = 0;
    for (int i = 0; i < 12; i++) begin
      if (processs != 2'b00) saw_issue = 1'b1;
      if (rsp_valid) begin
        check_eq("mis_err", rsp_err, 1);
        check_eq("mis_rdata", rsp_rdata, 0);
        nresp++;
        dir_ready = 1'b1;
      end else begin
        dir_ready = 1'b0;
      end
      @(negedge PCLK);
    end
    dir_ready = 1'b0;
    check_eq("mis_no_issue", saw_issue, 0);
    check_eq("mis_count", nresp, 2);

    push_cmd(1'b0, 32'h40, 32'h0, 2'b10);
    wait_issue("to");
    repeat (TIMEOUT) @(negedge PCLK);
    check_eq("to_early", rsp_valid, 0);
    @(negedge PCLK);
    check_eq("to_valid_at_16", rsp_valid, 1);
    take_rsp("to", 1'b1, 32'h0);
    push_cmd(1'b1, 32'h44, 32'h5555_AAAA, 2'b10);
    wait_issue("after_to");
    check_eq("after_to_op", processs, 2'b01);
    finish_xfer(TIMEOUT, 32'h7777_7777);
    take_rsp("edge_to", 1'b0, 32'h0);

    bg_on = 1'b1;
    while (n_pushed < N_RAND) begin
      @(negedge PCLK);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      if ($urandom_range(0, 1) == 0) cmd_addr[1:0] = 2'b00;
      sel       = $urandom_range(0, 7);
      cmd_size  = (sel == 7) ? 2'b11 : 2'(sel % 3);
      cmd_wdata = $urandom;
      if (cmd_valid && cmd_ready) begin
        nc = '{cmd_write, cmd_addr, cmd_wdata, cmd_size};
        exp_q.push_back(nc);
        if (!is_bad(nc)) bus_q.push_back(nc);
        n_pushed++;
      end
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    for (int n = 0; n < 5000 && n_rsp < n_pushed; n++) @(negedge PCLK);
    check_eq("rand_drain", n_rsp, n_pushed);
    check_eq("rand_leftover", exp_q.size(), 0);
    repeat (2) @(negedge PCLK);
    bg_on = 1'b0;
    @(negedge PCLK);

    push_cmd(1'b0, 32'h200, 32'h0, 2'b10);
    wait_issue("rst_mid");
    push_cmd(1'b0, 32'h204, 32'h0, 2'b10);
    push_cmd(1'b1, 32'h208, 32'h9, 2'b10);
    #2;
    PRESETn = 1'b0;
    #1;
    check_eq("rstm_processs", processs, 0);
    check_eq("rstm_address", address, 0);
    check_eq("rstm_write_data", write_data, 0);
    check_eq("rstm_data_size", data_size, 0);
    check_eq("rstm_rsp_valid", rsp_valid, 0);
    check_eq("rstm_cmd_ready", cmd_ready, 1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    saw_issue = 1'b0; saw_rsp = 1'b0;
    repeat (40) begin
      @(negedge PCLK);
      if (processs != 2'b00) saw_issue = 1'b1;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check_eq("rstm_no_issue", saw_issue, 0);
    check_eq("rstm_no_rsp", saw_rsp, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
